// File: rtl/cms_ctrl_sequencer.sv
// rtl/cms_ctrl_sequencer.sv - batched, ordered replay of host control writes into the monitor control port
//
// Host commands (cmd_addr/cmd_wdata) are queued in a DEPTH-entry FIFO. A command
// pushed with cmd_commit=1 releases itself and every earlier queued entry for
// issue. Each released entry is driven onto ctrl_addr/ctrl_wdata and framed by
// one SETUP cycle (write enable low, address/data stable), one STROBE cycle
// (write enable high) and GAP_CYCLES low cycles. This gives the monitor a clean
// rising edge per write.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   cmd_valid/ready    host push handshake; cmd_ready = FIFO not full
//   cmd_addr/wdata     queued control address and data
//   cmd_commit         pushed command closes a batch
//   cmd_flush          (CMS_CTRL_SEQ_FLUSH_EN only) drop all uncommitted entries
//   ctrl_addr/wdata    held control address/data towards the monitor
//   ctrl_write_enable  single-cycle write strobe
//   busy               sequencer active or committed work outstanding
//   pending            FIFO occupancy, committed plus uncommitted
//
// Optional build macro: CMS_CTRL_SEQ_FLUSH_EN adds the cmd_flush input.

module cms_ctrl_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [ADDR_WIDTH-1:0]      cmd_addr,
  input  logic [DATA_WIDTH-1:0]      cmd_wdata,
  input  logic                       cmd_commit,
`ifdef CMS_CTRL_SEQ_FLUSH_EN
  input  logic                       cmd_flush,
`endif
  output logic [ADDR_WIDTH-1:0]      ctrl_addr,
  output logic [DATA_WIDTH-1:0]      ctrl_wdata,
  output logic                       ctrl_write_enable,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] pending
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
  localparam logic [GW-1:0] GAP_INIT = GW'(GAP_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [PW-1:0] wr_ptr, rd_ptr, commit_ptr;
  logic [PW-1:0] count, committed_count;
  logic [GW-1:0] gap_cnt, gap_cnt_nxt;
  logic          has_committed;
  logic          push, pop, flush;

`ifdef CMS_CTRL_SEQ_FLUSH_EN
  assign flush = cmd_flush;
`else
  assign flush = 1'b0;
`endif

  assign count           = wr_ptr - rd_ptr;
  assign committed_count = commit_ptr - rd_ptr;
  assign has_committed   = (committed_count != '0);
  assign cmd_ready       = (count < DEPTH_P);
  assign pending         = CW'(count);
  assign busy            = (state != IDLE) || has_committed;

  // A flush on the same edge as an accepted push wins; the push is dropped.
  assign push = cmd_valid && cmd_ready && !flush;

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (has_committed) begin
          pop       = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        state_nxt = STROBE;
      end
      STROBE: begin
        state_nxt   = GAP;
        gap_cnt_nxt = GAP_INIT;
      end
      GAP: begin
        if (gap_cnt == GW'(1)) begin
          // Last low cycle: chain straight into the next write if one is released.
          if (has_committed) begin
            pop       = 1'b1;
            state_nxt = SETUP;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          gap_cnt_nxt = gap_cnt - GW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      gap_cnt           <= '0;
      ctrl_write_enable <= 1'b0;
    end else begin
      state             <= state_nxt;
      gap_cnt           <= gap_cnt_nxt;
      // Registered strobe: glitch-free, and the async reset clears it at once.
      ctrl_write_enable <= (state_nxt == STROBE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      commit_ptr <= '0;
      ctrl_addr  <= '0;
      ctrl_wdata <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (flush) begin
        wr_ptr <= commit_ptr;
      end else if (push) begin
        addr_mem[wr_ptr[IW-1:0]] <= cmd_addr;
        data_mem[wr_ptr[IW-1:0]] <= cmd_wdata;
        wr_ptr                   <= wr_ptr + PW'(1);
        if (cmd_commit) begin
          commit_ptr <= wr_ptr + PW'(1);
        end
      end
      // Address/data only change on a SETUP load, never while the strobe is high.
      if (pop) begin
        ctrl_addr  <= addr_mem[rd_ptr[IW-1:0]];
        ctrl_wdata <= data_mem[rd_ptr[IW-1:0]];
        rd_ptr     <= rd_ptr + PW'(1);
      end
    end
  end

endmodule
